// File: rtl/llki_pkg.sv
// Shared LLKI types: command opcodes, response status codes and key word width.
package llki_pkg;

    localparam int LLKI_KEY_W = 64;

    typedef enum logic {
        LLKI_LOAD_KEY  = 1'b0,
        LLKI_CLEAR_KEY = 1'b1
    } llki_op_e;

    typedef enum logic [1:0] {
        OK             = 2'd0,
        BAD_LEN        = 2'd1,
        TIMEOUT        = 2'd2,
        EARLY_COMPLETE = 2'd3
    } llki_status_e;

endpackage

// File: rtl/llki_timeout_ctr.sv
// Progress watchdog: counts enabled cycles since the last clear and flags the final one.
module llki_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Expiry is combinational so the owner can abort on the same edge.
    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/llki_discrete_master.sv
// LLKI discrete initiator: sequences load/clear commands onto the key_valid/key_ready
// and clear_key/clear_key_ack handshakes of one core's discrete slave.
module llki_discrete_master
    import llki_pkg::*;
#(
    parameter int MAX_WORDS      = 8,
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  wr_valid,
    input  logic [LLKI_KEY_W-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_status,
    input  logic                  rsp_ready,
    output logic [LLKI_KEY_W-1:0] llkid_key_data,
    output logic                  llkid_key_valid,
    input  logic                  llkid_key_ready,
    input  logic                  llkid_key_complete,
    output logic                  llkid_clear_key,
    input  logic                  llkid_clear_key_ack,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_CPL,
        S_CLEAR,
        S_WAIT_CLR_DROP,
        S_RESP
    } state_e;

    localparam logic [LEN_W:0] MAX_LEN = MAX_WORDS[LEN_W:0];

    state_e                  state, state_next;
    logic [LEN_W-1:0]        words_left, words_left_next;
    logic [LLKI_KEY_W-1:0]   key_data_q, key_data_next;
    logic                    key_valid_q, key_valid_next;
    logic                    clear_key_q, clear_key_next;
    llki_status_e            status_q, status_next;

    logic cmd_fire, wr_fire, key_xfer, last_xfer;
    logic tmo_clr, tmo_en, tmo_expire;

    function automatic logic len_is_bad(input logic [LEN_W-1:0] len);
        return (len == '0) || ({1'b0, len} > MAX_LEN);
    endfunction

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wr_fire   = wr_valid && wr_ready;
    assign key_xfer  = key_valid_q && llkid_key_ready;
    // words_left already counts down on acceptance, so zero here means the register holds the final word.
    assign last_xfer = key_xfer && (words_left == '0);

    // Starvation from upstream (no word held) must never count toward a timeout.
    assign tmo_en  = ((state == S_LOAD) && key_valid_q) || (state == S_WAIT_CPL) ||
                     (state == S_CLEAR) || (state == S_WAIT_CLR_DROP);
    assign tmo_clr = (state_next != state) || key_xfer;

    llki_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        words_left_next = words_left;
        key_data_next   = key_data_q;
        key_valid_next  = key_valid_q;
        clear_key_next  = clear_key_q;
        status_next     = status_q;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (llki_op_e'(cmd_op) == LLKI_CLEAR_KEY) begin
                        state_next     = S_CLEAR;
                        clear_key_next = 1'b1;
                    end else if (len_is_bad(cmd_len)) begin
                        state_next  = S_RESP;
                        status_next = BAD_LEN;
                    end else begin
                        state_next      = S_LOAD;
                        words_left_next = cmd_len;
                    end
                end
            end
            S_LOAD: begin
                if (wr_fire) begin
                    key_data_next   = wr_data;
                    key_valid_next  = 1'b1;
                    words_left_next = words_left - LEN_W'(1);
                end else if (key_xfer) begin
                    key_valid_next = 1'b0;
                end
                // A completion coincident with the final transfer is a normal finish, not an early one.
                if (last_xfer) begin
                    key_valid_next = 1'b0;
                    if (llkid_key_complete) begin
                        state_next  = S_RESP;
                        status_next = OK;
                    end else begin
                        state_next = S_WAIT_CPL;
                    end
                end else if (llkid_key_complete) begin
                    key_valid_next = 1'b0;
                    state_next     = S_RESP;
                    status_next    = EARLY_COMPLETE;
                end else if (tmo_expire && !key_xfer) begin
                    key_valid_next = 1'b0;
                    state_next     = S_RESP;
                    status_next    = TIMEOUT;
                end
            end
            S_WAIT_CPL: begin
                if (llkid_key_complete) begin
                    state_next  = S_RESP;
                    status_next = OK;
                end else if (tmo_expire) begin
                    state_next  = S_RESP;
                    status_next = TIMEOUT;
                end
            end
            S_CLEAR: begin
                if (llkid_clear_key_ack) begin
                    clear_key_next = 1'b0;
                    state_next     = S_WAIT_CLR_DROP;
                end else if (tmo_expire) begin
                    clear_key_next = 1'b0;
                    state_next     = S_RESP;
                    status_next    = TIMEOUT;
                end
            end
            S_WAIT_CLR_DROP: begin
                // Waiting for ack to fall keeps a lingering ack from satisfying the next clear.
                if (!llkid_clear_key_ack) begin
                    state_next  = S_RESP;
                    status_next = OK;
                end else if (tmo_expire) begin
                    state_next  = S_RESP;
                    status_next = TIMEOUT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                cmd_ready = !reset;
                busy      = 1'b0;
            end
            S_LOAD:  wr_ready  = (words_left != '0) && (!key_valid_q || llkid_key_ready);
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            words_left  <= '0;
            key_data_q  <= '0;
            key_valid_q <= 1'b0;
            clear_key_q <= 1'b0;
            status_q    <= OK;
        end else begin
            words_left  <= words_left_next;
            key_data_q  <= key_data_next;
            key_valid_q <= key_valid_next;
            clear_key_q <= clear_key_next;
            status_q    <= status_next;
        end
    end

    assign llkid_key_data  = key_data_q;
    assign llkid_key_valid = key_valid_q;
    assign llkid_clear_key = clear_key_q;
    assign rsp_status      = status_q;

endmodule
